// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative cache way array:
// FSM state encoding, derived widths and tree-PLRU victim/update functions.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    WRITE,
    MISS
  } state_t;

  localparam int MAX_WAYS = 4;
  localparam int PLRU_W   = MAX_WAYS - 1;

  function automatic int words_of(input int offset_w);
    return 1 << (offset_w - 2);
  endfunction

  function automatic int way_w_of(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  // Tree layout: bit 0 is the root, bit 1 covers ways 0/1, bit 2 covers ways 2/3.
  // A 0 bit points the victim search left, a 1 bit points it right.
  function automatic logic [1:0] plru_victim(input logic [PLRU_W-1:0] bits, input int ways);
    logic [1:0] victim;
    victim = 2'd0;
    if (ways == 2) begin
      victim = {1'b0, bits[0]};
    end else if (ways == 4) begin
      victim = bits[0] ? {1'b1, bits[2]} : {1'b0, bits[1]};
    end
    return victim;
  endfunction

  function automatic logic [PLRU_W-1:0] plru_update(input logic [PLRU_W-1:0] bits,
                                                    input logic [1:0]        way,
                                                    input int                ways);
    logic [PLRU_W-1:0] next_bits;
    next_bits = bits;
    if (ways == 2) begin
      next_bits[0] = ~way[0];
    end else if (ways == 4) begin
      next_bits[0] = ~way[1];
      if (way[1]) next_bits[2] = ~way[0];
      else        next_bits[1] = ~way[0];
    end
    return next_bits;
  endfunction

endpackage

// File: rtl/cache_sram_1rw.sv
// Single-port RAM with byte-lane write enables, one-cycle registered read,
// write-first read-during-write. Output holds its value while en is low.
module cache_sram_1rw #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 32,
  parameter int BE_W  = 8
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH/BE_W-1:0]    be,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  localparam int NBE = WIDTH / BE_W;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] merged;

  always_comb begin
    merged = mem[addr];
    for (int b = 0; b < NBE; b++) begin
      if (be[b]) merged[b*BE_W +: BE_W] = wdata[b*BE_W +: BE_W];
    end
  end

  // NOTE: array storage is deliberately not reset; validity lives in separate flops.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= merged;
      rdata <= we ? merged : mem[addr];
    end
  end

endmodule

// File: rtl/cache_way_array.sv
// N-way set-associative tag/data array with one-cycle lookup, store-hit write,
// blocking refill on miss and tree-PLRU replacement.
module cache_way_array
  import cache_pkg::*;
#(
  parameter int WAYS     = 2,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 4,
  parameter int TAG_W    = 32 - INDEX_W - OFFSET_W
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [INDEX_W-1:0]               req_index,
  input  logic [TAG_W-1:0]                 req_tag,
  input  logic [OFFSET_W-1:0]              req_offset,
  input  logic [3:0]                       req_wstrb,
  input  logic [31:0]                      req_wdata,
  output logic                             rsp_valid,
  output logic                             rsp_hit,
  output logic                             rsp_refill,
  output logic [way_w_of(WAYS)-1:0]        rsp_way,
  output logic [31:0]                      rsp_rdata,
  output logic                             victim_dirty,
  output logic [TAG_W-1:0]                 victim_tag,
  output logic [32*words_of(OFFSET_W)-1:0] victim_line,
  input  logic                             refill_valid,
  input  logic [32*words_of(OFFSET_W)-1:0] refill_line
);

  localparam int WORDS  = words_of(OFFSET_W);
  localparam int WAY_W  = way_w_of(WAYS);
  localparam int WSEL_W = OFFSET_W - 2;
  localparam int SETS   = 1 << INDEX_W;
  localparam int PL_W   = (WAYS > 1) ? WAYS - 1 : 1;

  state_t state_q, state_d;

  logic [INDEX_W-1:0] idx_q;
  logic [TAG_W-1:0]   tag_q;
  logic [WSEL_W-1:0]  word_q;
  logic [3:0]         wstrb_q;
  logic [31:0]        wdata_q;
  logic [WAY_W-1:0]   way_q;

  logic [WAYS-1:0] valid_q [SETS];
  logic [WAYS-1:0] dirty_q [SETS];
  logic [PL_W-1:0] plru_q  [SETS];

  logic [WAYS-1:0] set_valid, set_dirty;
  logic [PL_W-1:0] set_plru;

  logic             accept, is_store, hit;
  logic             refill_we, word_we;
  logic [WAY_W-1:0] hit_way, alloc_way, lookup_way, victim_way;

  logic [INDEX_W-1:0] ram_addr;
  logic [WAYS-1:0]    tag_en;
  logic [TAG_W-1:0]   tag_rd      [WAYS];
  logic [31:0]        data_rd     [WAYS][WORDS];
  logic               data_en     [WAYS][WORDS];
  logic [3:0]         data_be     [WAYS][WORDS];
  logic [31:0]        data_wdata  [WAYS][WORDS];
  logic [31:0]        refill_word [WORDS];

  logic unused_offset_bits;
  assign unused_offset_bits = ^req_offset[1:0];

  assign set_valid = valid_q[idx_q];
  assign set_dirty = dirty_q[idx_q];
  assign set_plru  = plru_q[idx_q];
  assign is_store  = |wstrb_q;
  assign accept    = req_valid && req_ready;

  // Invalid ways are filled lowest-first; only a full set consults the PLRU tree.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (set_valid[w] && tag_rd[w] == tag_q) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    alloc_way = WAY_W'(plru_victim(PLRU_W'(set_plru), WAYS));
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!set_valid[w]) alloc_way = WAY_W'(w);
    end
    lookup_way = hit ? hit_way : alloc_way;
  end

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_refill = 1'b0;
    refill_we  = 1'b0;
    word_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = LOOKUP;
      end
      LOOKUP: begin
        rsp_valid = 1'b1;
        if (hit && !is_store) begin
          req_ready = 1'b1;
          state_d   = req_valid ? LOOKUP : IDLE;
        end else if (hit) begin
          state_d = WRITE;
        end else begin
          state_d = MISS;
        end
      end
      WRITE: begin
        word_we = 1'b1;
        state_d = IDLE;
      end
      MISS: begin
        if (refill_valid) begin
          refill_we  = 1'b1;
          rsp_valid  = 1'b1;
          rsp_refill = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending store bytes are merged over the incoming line before it is written.
  always_comb begin
    for (int k = 0; k < WORDS; k++) begin
      refill_word[k] = refill_line[32*k +: 32];
      if (is_store && word_q == WSEL_W'(k)) begin
        for (int b = 0; b < 4; b++) begin
          if (wstrb_q[b]) refill_word[k][8*b +: 8] = wdata_q[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    ram_addr = (state_q == WRITE || state_q == MISS) ? idx_q : req_index;
    for (int w = 0; w < WAYS; w++) begin
      tag_en[w] = accept || (refill_we && way_q == WAY_W'(w));
      for (int k = 0; k < WORDS; k++) begin
        data_en[w][k]    = accept || (refill_we && way_q == WAY_W'(w))
                         || (word_we && way_q == WAY_W'(w) && word_q == WSEL_W'(k));
        data_be[w][k]    = refill_we ? 4'hF : wstrb_q;
        data_wdata[w][k] = refill_we ? refill_word[k] : wdata_q;
      end
    end
  end

  // RAM outputs hold through MISS, so the victim stays visible on the refill response.
  always_comb begin
    rsp_hit      = 1'b0;
    rsp_way      = '0;
    rsp_rdata    = '0;
    victim_dirty = 1'b0;
    victim_tag   = '0;
    victim_line  = '0;
    victim_way   = (state_q == LOOKUP) ? alloc_way : way_q;
    if (state_q == LOOKUP) begin
      rsp_hit   = hit;
      rsp_way   = lookup_way;
      rsp_rdata = data_rd[lookup_way][word_q];
    end else if (refill_we) begin
      rsp_way   = way_q;
      rsp_rdata = refill_word[word_q];
    end
    if (rsp_valid && !rsp_hit) begin
      victim_dirty = set_valid[victim_way] && set_dirty[victim_way];
      victim_tag   = tag_rd[victim_way];
      for (int k = 0; k < WORDS; k++) victim_line[32*k +: 32] = data_rd[victim_way][k];
    end
  end

  // NOTE: clocked blocks use non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q <= state_d;
      if (state_q == LOOKUP && hit) begin
        plru_q[idx_q] <= PL_W'(plru_update(PLRU_W'(set_plru), 2'(hit_way), WAYS));
      end
      if (word_we) dirty_q[idx_q][way_q] <= 1'b1;
      if (refill_we) begin
        valid_q[idx_q][way_q] <= 1'b1;
        dirty_q[idx_q][way_q] <= is_store;
        plru_q[idx_q]         <= PL_W'(plru_update(PLRU_W'(set_plru), 2'(way_q), WAYS));
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx_q   <= '0;
      tag_q   <= '0;
      word_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      way_q   <= '0;
    end else begin
      if (accept) begin
        idx_q   <= req_index;
        tag_q   <= req_tag;
        word_q  <= req_offset[OFFSET_W-1:2];
        wstrb_q <= req_wstrb;
        wdata_q <= req_wdata;
      end
      if (state_q == LOOKUP) way_q <= lookup_way;
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_sram_1rw #(.DEPTH(SETS), .WIDTH(TAG_W), .BE_W(TAG_W)) u_tag (
      .clk   (clk),
      .en    (tag_en[w]),
      .we    (refill_we),
      .addr  (ram_addr),
      .be    (1'b1),
      .wdata (tag_q),
      .rdata (tag_rd[w])
    );
    for (genvar k = 0; k < WORDS; k++) begin : g_word
      cache_sram_1rw #(.DEPTH(SETS), .WIDTH(32), .BE_W(8)) u_data (
        .clk   (clk),
        .en    (data_en[w][k]),
        .we    (refill_we || word_we),
        .addr  (ram_addr),
        .be    (data_be[w][k]),
        .wdata (data_wdata[w][k]),
        .rdata (data_rd[w][k])
      );
    end
  end

endmodule

// File: tb/tb_cache_way_array.sv
// Directed bench for cache_way_array: a 2-way and a 4-way instance driven
// from a vector table plus hand-written back-to-back and reset-in-MISS sequences.
module tb_cache_way_array;

  localparam logic [127:0] LINE_A  = {32'h10FFEEDD, 32'hCCBBAA99, 32'h88776655, 32'h44332211};
  localparam logic [127:0] LINE_AS = {32'h10FFEEDD, 32'hCCBBAA99, 32'h88776655, 32'h4433BBBB};
  localparam logic [127:0] LINE_B  = {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0};
  localparam logic [127:0] LINE_C  = {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};
  localparam logic [127:0] LINE_CS = {32'h5566C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};

  typedef struct {
    logic         sel;
    logic [7:0]   idx;
    logic [19:0]  tag;
    logic [3:0]   off;
    logic [3:0]   ws;
    logic [31:0]  wd;
    logic [127:0] line;
    logic         hit;
    logic [1:0]   way;
    logic [31:0]  rdata;
    logic         vdirty;
    logic [19:0]  vtag;
    logic [127:0] vline;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         resetn;
  logic [7:0]   req_index;
  logic [19:0]  req_tag;
  logic [3:0]   req_offset, req_wstrb;
  logic [31:0]  req_wdata;
  logic [127:0] refill_line;

  logic         req_valid2, refill_valid2, rdy2, rv2, hit2, rf2, vd2;
  logic [0:0]   way2;
  logic [31:0]  rd2;
  logic [19:0]  vt2;
  logic [127:0] vl2;

  logic         req_valid4, refill_valid4, rdy4, rv4, hit4, rf4, vd4;
  logic [1:0]   way4;
  logic [31:0]  rd4;
  logic [19:0]  vt4;
  logic [127:0] vl4;

  cache_way_array #(.WAYS(2), .INDEX_W(8), .OFFSET_W(4)) u_dut2 (
    .clk(clk), .resetn(resetn), .req_valid(req_valid2), .req_ready(rdy2),
    .req_index(req_index), .req_tag(req_tag), .req_offset(req_offset),
    .req_wstrb(req_wstrb), .req_wdata(req_wdata), .rsp_valid(rv2), .rsp_hit(hit2),
    .rsp_refill(rf2), .rsp_way(way2), .rsp_rdata(rd2), .victim_dirty(vd2),
    .victim_tag(vt2), .victim_line(vl2), .refill_valid(refill_valid2),
    .refill_line(refill_line)
  );

  cache_way_array #(.WAYS(4), .INDEX_W(8), .OFFSET_W(4)) u_dut4 (
    .clk(clk), .resetn(resetn), .req_valid(req_valid4), .req_ready(rdy4),
    .req_index(req_index), .req_tag(req_tag), .req_offset(req_offset),
    .req_wstrb(req_wstrb), .req_wdata(req_wdata), .rsp_valid(rv4), .rsp_hit(hit4),
    .rsp_refill(rf4), .rsp_way(way4), .rsp_rdata(rd4), .victim_dirty(vd4),
    .victim_tag(vt4), .victim_line(vl4), .refill_valid(refill_valid4),
    .refill_line(refill_line)
  );

  logic         cur_sel;
  logic         cur_ready, cur_valid, cur_hit, cur_refill, cur_vd;
  logic [1:0]   cur_way;
  logic [31:0]  cur_rdata;
  logic [19:0]  cur_vtag;
  logic [127:0] cur_vline;

  always_comb begin
    cur_ready  = cur_sel ? rdy4 : rdy2;
    cur_valid  = cur_sel ? rv4  : rv2;
    cur_hit    = cur_sel ? hit4 : hit2;
    cur_refill = cur_sel ? rf4  : rf2;
    cur_way    = cur_sel ? way4 : {1'b0, way2};
    cur_rdata  = cur_sel ? rd4  : rd2;
    cur_vd     = cur_sel ? vd4  : vd2;
    cur_vtag   = cur_sel ? vt4  : vt2;
    cur_vline  = cur_sel ? vl4  : vl2;
  end

  logic         g_valid, g_hit, g_refill, g_vd;
  logic [1:0]   g_way;
  logic [31:0]  g_rdata;
  logic [19:0]  g_vtag;
  logic [127:0] g_vline;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic sample();
    g_valid  = cur_valid;
    g_hit    = cur_hit;
    g_refill = cur_refill;
    g_way    = cur_way;
    g_rdata  = cur_rdata;
    g_vd     = cur_vd;
    g_vtag   = cur_vtag;
    g_vline  = cur_vline;
  endtask

  task automatic lookup(input logic sel, input logic [7:0] idx, input logic [19:0] tag,
                        input logic [3:0] off, input logic [3:0] ws, input logic [31:0] wd);
    int budget;
    cur_sel = sel;
    @(negedge clk);
    req_index  = idx;
    req_tag    = tag;
    req_offset = off;
    req_wstrb  = ws;
    req_wdata  = wd;
    if (sel) req_valid4 = 1'b1;
    else     req_valid2 = 1'b1;
    budget = 0;
    while (!cur_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check("accept_ready", cur_ready, 1'b1);
    @(negedge clk);
    req_valid2 = 1'b0;
    req_valid4 = 1'b0;
    sample();
  endtask

  task automatic refill(input logic sel, input logic [127:0] line);
    cur_sel = sel;
    @(negedge clk);
    refill_line = line;
    if (sel) refill_valid4 = 1'b1;
    else     refill_valid2 = 1'b1;
    #1 sample();
    @(posedge clk);
    #1;
    refill_valid2 = 1'b0;
    refill_valid4 = 1'b0;
  endtask

  task automatic add(input logic sel, input logic [7:0] idx, input logic [19:0] tag,
                     input logic [3:0] off, input logic [3:0] ws, input logic [31:0] wd,
                     input logic [127:0] line, input logic hit, input logic [1:0] way,
                     input logic [31:0] rdata, input logic vdirty, input logic [19:0] vtag,
                     input logic [127:0] vline);
    vec_t v;
    v = '{sel, idx, tag, off, ws, wd, line, hit, way, rdata, vdirty, vtag, vline};
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] b2b_tag [4];
    logic [3:0]  b2b_off [4];
    logic [31:0] b2b_exp [4];

    // 2-way, set 5: fill, store hit, dirty eviction, PLRU steering.
    add(0, 5, 20'h12345, 4'h0, 4'h0, 32'h0,        LINE_A, 0, 0, 32'h44332211, 0, 0, 0);
    add(0, 5, 20'h12345, 4'h0, 4'h0, 32'h0,        0,      1, 0, 32'h44332211, 0, 0, 0);
    add(0, 5, 20'h12345, 4'h0, 4'h3, 32'hAAAABBBB, 0,      1, 0, 32'h44332211, 0, 0, 0);
    add(0, 5, 20'h12345, 4'h0, 4'h0, 32'h0,        0,      1, 0, 32'h4433BBBB, 0, 0, 0);
    add(0, 5, 20'h12345, 4'h8, 4'h0, 32'h0,        0,      1, 0, 32'hCCBBAA99, 0, 0, 0);
    add(0, 5, 20'h00777, 4'h4, 4'h0, 32'h0,        LINE_B, 0, 1, 32'hB1B1B1B1, 0, 0, 0);
    add(0, 5, 20'h00888, 4'hC, 4'hC, 32'h55667788, LINE_C, 0, 0, 32'h5566C3C3, 1, 20'h12345, LINE_AS);
    add(0, 5, 20'h00888, 4'hC, 4'h0, 32'h0,        0,      1, 0, 32'h5566C3C3, 0, 0, 0);
    add(0, 5, 20'h00777, 4'h4, 4'h0, 32'h0,        0,      1, 1, 32'hB1B1B1B1, 0, 0, 0);
    add(0, 5, 20'h00999, 4'h0, 4'h0, 32'h0,        LINE_A, 0, 0, 32'h44332211, 1, 20'h00888, LINE_CS);
    add(0, 6, 20'h12345, 4'h0, 4'h0, 32'h0,        LINE_B, 0, 0, 32'hB0B0B0B0, 0, 0, 0);
    add(0, 5, 20'h00999, 4'h0, 4'h0, 32'h0,        0,      1, 0, 32'h44332211, 0, 0, 0);
    // 4-way, set 9: fill all ways, touch 0..3, then PLRU-chosen victims.
    for (int w = 0; w < 4; w++)
      add(1, 9, 20'h00100 + 20'(w), 4'h0, 4'h0, 32'h0, LINE_B, 0, 2'(w), 32'hB0B0B0B0, 0, 0, 0);
    for (int w = 0; w < 4; w++)
      add(1, 9, 20'h00100 + 20'(w), 4'h0, 4'h0, 32'h0, 0,      1, 2'(w), 32'hB0B0B0B0, 0, 0, 0);
    add(1, 9, 20'h00104, 4'h0, 4'h0, 32'h0, LINE_C, 0, 0, 32'hC0C0C0C0, 0, 0, 0);
    add(1, 9, 20'h00104, 4'h0, 4'h0, 32'h0, 0,      1, 0, 32'hC0C0C0C0, 0, 0, 0);
    add(1, 9, 20'h00105, 4'h0, 4'h0, 32'h0, LINE_A, 0, 2, 32'h44332211, 0, 0, 0);
    add(1, 9, 20'h00102, 4'h0, 4'h0, 32'h0, LINE_B, 0, 1, 32'hB0B0B0B0, 0, 0, 0);

    cur_sel       = 1'b0;
    resetn        = 1'b0;
    req_valid2    = 1'b0;
    req_valid4    = 1'b0;
    refill_valid2 = 1'b0;
    refill_valid4 = 1'b0;
    req_index     = '0;
    req_tag       = '0;
    req_offset    = '0;
    req_wstrb     = '0;
    req_wdata     = '0;
    refill_line   = '0;
    repeat (3) @(negedge clk);
    check("reset_rsp_valid2", rv2, 1'b0);
    check("reset_rsp_valid4", rv4, 1'b0);
    resetn = 1'b1;
    @(negedge clk);
    check("post_reset_ready2", rdy2, 1'b1);
    check("post_reset_ready4", rdy4, 1'b1);
    check("post_reset_way2", way2, 1'b0);

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      lookup(v.sel, v.idx, v.tag, v.off, v.ws, v.wd);
      check($sformatf("v%0d_valid", i), g_valid, 1'b1);
      check($sformatf("v%0d_hit", i), g_hit, v.hit);
      check($sformatf("v%0d_way", i), g_way, v.way);
      if (v.hit) begin
        check($sformatf("v%0d_rdata", i), g_rdata, v.rdata);
      end else begin
        check($sformatf("v%0d_vdirty", i), g_vd, v.vdirty);
        if (v.vdirty) begin
          check($sformatf("v%0d_vtag", i), g_vtag, v.vtag);
          check($sformatf("v%0d_vline", i), g_vline, v.vline);
        end
        refill(v.sel, v.line);
        check($sformatf("v%0d_rf_valid", i), g_valid, 1'b1);
        check($sformatf("v%0d_rf_flag", i), g_refill, 1'b1);
        check($sformatf("v%0d_rf_hit", i), g_hit, 1'b0);
        check($sformatf("v%0d_rf_way", i), g_way, v.way);
        check($sformatf("v%0d_rf_rdata", i), g_rdata, v.rdata);
      end
    end

    // Back-to-back load hits on 2-way set 5: one request per cycle.
    b2b_tag = '{20'h00999, 20'h00777, 20'h00999, 20'h00777};
    b2b_off = '{4'h0, 4'h4, 4'h8, 4'h0};
    b2b_exp = '{32'h44332211, 32'hB1B1B1B1, 32'hCCBBAA99, 32'hB0B0B0B0};
    cur_sel = 1'b0;
    @(negedge clk);
    check("b2b_ready0", rdy2, 1'b1);
    req_index  = 8'd5;
    req_tag    = b2b_tag[0];
    req_offset = b2b_off[0];
    req_wstrb  = 4'h0;
    req_valid2 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("b2b%0d_valid", k-1), rv2, 1'b1);
      check($sformatf("b2b%0d_hit", k-1), hit2, 1'b1);
      check($sformatf("b2b%0d_rdata", k-1), rd2, b2b_exp[k-1]);
      check($sformatf("b2b%0d_ready", k-1), rdy2, 1'b1);
      if (k < 4) begin
        req_tag    = b2b_tag[k];
        req_offset = b2b_off[k];
      end else begin
        req_valid2 = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b_idle_no_rsp", rv2, 1'b0);

    // Reset while waiting for a refill abandons the miss.
    lookup(0, 7, 20'h00ABC, 4'h0, 4'h0, 32'h0);
    check("rst_miss_hit", g_hit, 1'b0);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("rst_in_miss_valid", rv2, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("rst_release_ready", rdy2, 1'b1);
    refill_line   = LINE_C;
    refill_valid2 = 1'b1;
    #1;
    check("stray_refill_valid", rv2, 1'b0);
    check("stray_refill_flag", rf2, 1'b0);
    @(posedge clk);
    #1;
    refill_valid2 = 1'b0;
    check("stray_refill_after", rv2, 1'b0);
    lookup(0, 7, 20'h00ABC, 4'h0, 4'h0, 32'h0);
    check("rst_relookup_hit", g_hit, 1'b0);
    check("rst_relookup_way", g_way, 2'd0);
    refill(0, LINE_B);
    check("rst_refill_rdata", g_rdata, 32'hB0B0B0B0);
    lookup(0, 5, 20'h00999, 4'h0, 4'h0, 32'h0);
    check("rst_cleared_hit", g_hit, 1'b0);
    check("rst_cleared_vdirty", g_vd, 1'b0);
    refill(0, LINE_A);
    check("rst_cleared_rf_way", g_way, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
